// File: rtl/data_memory_ctrl.sv
// ============================================================================
// data_memory_ctrl
//
// Synchronous single-port data memory for the CPU datapath. Reads come back
// one cycle after the request, together with a valid strobe. Accesses to
// addresses at or beyond DEPTH are suppressed and flagged. The whole array
// can be erased by a one-word-per-cycle sweep, during which the block reports
// busy and ignores read/write requests.
//
// Parameters:
//   DATA_WIDTH     word width in bits
//   ADDR_WIDTH     address bus width in bits
//   DEPTH          number of words (1 <= DEPTH <= 2**ADDR_WIDTH)
//   CLEAR_ON_RESET 1: reset starts an erase sweep, 0: reset keeps contents
//
// Ports:
//   clk            rising-edge clock
//   clear          synchronous active-high reset
//   address        word address for a read or write
//   data_to_write  write data
//   writeif        write request
//   readif         read request
//   wipe           request a full-array erase sweep
//   output_data    registered read data
//   read_valid     output_data belongs to the read accepted on the last edge
//   busy           erase sweep in progress, requests are not accepted
//   addr_error     the access accepted on the last edge was out of range
// ============================================================================
module data_memory_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int DEPTH          = 100,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_to_write,
    input  logic                  writeif,
    input  logic                  readif,
    input  logic                  wipe,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  addr_error
);

    // Array index width; a single-word memory still needs a 1-bit index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH may equal 2**ADDR_WIDTH, so the bound needs one extra bit to
    // keep the range check a plain unsigned compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ERASE = 1'b1
    } state_e;

    // Storage: one write port, read result captured into output_data_q.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] output_data_q, output_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  addr_error_q, addr_error_d;

    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Range check on the full unsigned address; only a passing address is
    // allowed to drive the array index, otherwise the index is parked at 0.
    always_comb begin
        in_range = ({1'b0, address} < DEPTH_EXT);
        idx      = in_range ? address[IDX_W-1:0] : '0;
    end

    // Next-state logic. In IDLE a wipe wins over any read/write in the same
    // cycle. A read and write to the same word return the old contents
    // because the read value is taken from the array before the edge that
    // performs the write. In ERASE the sweep pointer drives the write port.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        output_data_d = output_data_q;
        read_valid_d  = 1'b0;
        addr_error_d  = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = idx;
        mem_wdata     = data_to_write;

        case (state_q)
            ST_IDLE: begin
                if (wipe) begin
                    state_d = ST_ERASE;
                    ptr_d   = '0;
                end else begin
                    if (writeif || readif) begin
                        addr_error_d = !in_range;
                    end
                    if (readif) begin
                        read_valid_d  = 1'b1;
                        output_data_d = in_range ? mem[idx] : '0;
                    end
                    if (writeif && in_range) begin
                        mem_we = 1'b1;
                    end
                end
            end

            ST_ERASE: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Control and output registers. Reset overrides everything, including
    // a sweep in progress, which therefore restarts from word 0.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= CLEAR_ON_RESET ? ST_ERASE : ST_IDLE;
            ptr_q         <= '0;
            output_data_q <= '0;
            read_valid_q  <= 1'b0;
            addr_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            output_data_q <= output_data_d;
            read_valid_q  <= read_valid_d;
            addr_error_q  <= addr_error_d;
        end
    end

    // Array write port, kept free of reset so it maps onto a RAM primitive.
    // A reset cycle never writes, so contents survive when no sweep follows.
    always_ff @(posedge clk) begin
        if (mem_we && !clear) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign output_data = output_data_q;
    assign read_valid  = read_valid_q;
    assign addr_error  = addr_error_q;
    assign busy        = (state_q == ST_ERASE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ============================================================================
// tb_data_memory_ctrl
//
// Exercises a default-parameter memory (16-bit, 100 words, erase on reset)
// against an array-based reference model, plus a second instance with
// 32-bit words, 16 words and no erase on reset.
// ============================================================================
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        clear = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] data_to_write = '0;
    logic        writeif = 1'b0;
    logic        readif = 1'b0;
    logic        wipe = 1'b0;
    logic [15:0] output_data;
    logic        read_valid;
    logic        busy;
    logic        addr_error;

    // Overridden-parameter instance
    logic        clear2 = 1'b0;
    logic [15:0] address2 = '0;
    logic [31:0] data2 = '0;
    logic        writeif2 = 1'b0;
    logic        readif2 = 1'b0;
    logic        wipe2 = 1'b0;
    logic [31:0] output_data2;
    logic        read_valid2;
    logic        busy2;
    logic        addr_error2;

    int vectors = 0;
    int miscompares = 0;

    // Reference model for the default instance
    logic [15:0] model_mem [100];
    logic [15:0] exp_out;

    data_memory_ctrl dut (
        .clk           (clk),
        .clear         (clear),
        .address       (address),
        .data_to_write (data_to_write),
        .writeif       (writeif),
        .readif        (readif),
        .wipe          (wipe),
        .output_data   (output_data),
        .read_valid    (read_valid),
        .busy          (busy),
        .addr_error    (addr_error)
    );

    data_memory_ctrl #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (16),
        .DEPTH          (16),
        .CLEAR_ON_RESET (1'b0)
    ) dut2 (
        .clk           (clk),
        .clear         (clear2),
        .address       (address2),
        .data_to_write (data2),
        .writeif       (writeif2),
        .readif        (readif2),
        .wipe          (wipe2),
        .output_data   (output_data2),
        .read_valid    (read_valid2),
        .busy          (busy2),
        .addr_error    (addr_error2)
    );

    // Advance one edge and settle just after it
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one instance for a single cycle while the other stays idle
    task automatic applyStimulus(input int sel, input logic clr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic we, input logic re,
                                 input logic wp);
        if (sel == 0) begin
            clear = clr; address = addr[15:0]; data_to_write = data[15:0];
            writeif = we; readif = re; wipe = wp;
            clear2 = 1'b0; writeif2 = 1'b0; readif2 = 1'b0; wipe2 = 1'b0;
        end else begin
            clear2 = clr; address2 = addr[15:0]; data2 = data;
            writeif2 = we; readif2 = re; wipe2 = wp;
            clear = 1'b0; writeif = 1'b0; readif = 1'b0; wipe = 1'b0;
        end
        waitCycle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One read/write cycle on the default instance, predicted from the model
    task automatic doOp(input int addr, input logic [15:0] data, input logic we,
                        input logic re, input string tag);
        bit   inr;
        logic exp_rv;
        logic exp_err;
        inr     = (addr < 100);
        exp_rv  = re;
        exp_err = (we || re) && !inr;
        if (re) exp_out = inr ? model_mem[addr] : 16'h0000;
        if (we && inr) model_mem[addr] = data;
        applyStimulus(0, 1'b0, 32'(addr), 32'(data), we, re, 1'b0);
        checkOutput({tag, ".data"}, 32'(output_data), 32'(exp_out));
        checkOutput({tag, ".valid"}, 32'(read_valid), 32'(exp_rv));
        checkOutput({tag, ".err"}, 32'(addr_error), 32'(exp_err));
    endtask

    // Idle the default instance until busy drops; optional wipe pulse at
    // a given cycle of the sweep
    task automatic countBusy(input int wipe_at, output int cycles);
        cycles = 0;
        while (busy && cycles < 300) begin
            applyStimulus(0, 1'b0, 32'(cycles), 32'hFFFF, 1'b1, 1'b1, (cycles == wipe_at));
            cycles++;
        end
    endtask

    initial begin
        int cycles;
        int a;
        logic [15:0] d;
        logic we;
        logic re;

        // Reset both instances together
        clear = 1'b1; clear2 = 1'b1;
        waitCycle();
        checkOutput("rst.busy", 32'(busy), 32'd1);
        checkOutput("rst.data", 32'(output_data), 32'd0);
        checkOutput("rst.valid", 32'(read_valid), 32'd0);
        checkOutput("rst.err", 32'(addr_error), 32'd0);
        checkOutput("rst2.busy", 32'(busy2), 32'd0);
        checkOutput("rst2.data", output_data2, 32'd0);
        checkOutput("rst2.valid", 32'(read_valid2), 32'd0);

        // Sweep after reset lasts exactly DEPTH cycles
        countBusy(-1, cycles);
        checkOutput("rst_sweep_len", 32'(cycles), 32'd100);
        for (int i = 0; i < 100; i++) model_mem[i] = 16'h0000;
        exp_out = 16'h0000;
        $display("[TB] reset sweep finished after %0d cycles", cycles);

        doOp(0, 16'h0, 1'b0, 1'b1, "rd0");
        doOp(50, 16'h0, 1'b0, 1'b1, "rd50");
        doOp(99, 16'h0, 1'b0, 1'b1, "rd99");
        checkOutput("rd99.zero", 32'(output_data), 32'h0000);
        doOp(0, 16'h0, 1'b0, 1'b0, "idle_after_rd");

        // Write then read back
        doOp(7, 16'hBEEF, 1'b1, 1'b0, "wr7");
        doOp(7, 16'h0, 1'b0, 1'b1, "rd7");
        checkOutput("rd7.beef", 32'(output_data), 32'hBEEF);

        // Simultaneous read and write: read-first
        doOp(7, 16'h1234, 1'b1, 1'b1, "rw7");
        checkOutput("rw7.old", 32'(output_data), 32'hBEEF);
        doOp(7, 16'h0, 1'b0, 1'b1, "rd7b");
        checkOutput("rd7b.new", 32'(output_data), 32'h1234);

        // Out-of-range accesses
        doOp(100, 16'hAAAA, 1'b1, 1'b0, "wr100");
        checkOutput("wr100.flag", 32'(addr_error), 32'd1);
        doOp(100, 16'h0, 1'b0, 1'b1, "rd100");
        checkOutput("rd100.flag", 32'(addr_error), 32'd1);
        checkOutput("rd100.zero", 32'(output_data), 32'h0000);
        doOp(99, 16'h0, 1'b0, 1'b1, "rd99b");
        checkOutput("rd99b.kept", 32'(output_data), 32'h0000);

        // Randomized traffic, including out-of-range addresses
        for (int i = 0; i < 80; i++) begin
            a  = int'($urandom_range(119, 0));
            d  = 16'($urandom);
            we = 1'($urandom_range(1, 0));
            re = 1'($urandom_range(1, 0));
            doOp(a, d, we, re, "rand");
        end

        // Fill, wipe, then reset mid-sweep
        for (int i = 0; i < 100; i++) doOp(i, 16'(i + 1), 1'b1, 1'b0, "fill");
        doOp(42, 16'h0, 1'b0, 1'b1, "fill_rd42");
        checkOutput("fill_rd42.val", 32'(output_data), 32'd43);

        applyStimulus(0, 1'b0, 32'd5, 32'h5555, 1'b1, 1'b1, 1'b1);
        checkOutput("wipe.busy", 32'(busy), 32'd1);
        checkOutput("wipe.valid", 32'(read_valid), 32'd0);
        checkOutput("wipe.data_hold", 32'(output_data), 32'(exp_out));

        applyStimulus(0, 1'b0, 32'd3, 32'hFFFF, 1'b1, 1'b0, 1'b0);
        checkOutput("sweep_wr.busy", 32'(busy), 32'd1);
        checkOutput("sweep_wr.valid", 32'(read_valid), 32'd0);
        checkOutput("sweep_wr.err", 32'(addr_error), 32'd0);
        for (int i = 2; i < 40; i++) applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("sweep39.busy", 32'(busy), 32'd1);

        applyStimulus(0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst.busy", 32'(busy), 32'd1);
        checkOutput("midrst.data", 32'(output_data), 32'd0);
        checkOutput("midrst.valid", 32'(read_valid), 32'd0);
        exp_out = 16'h0000;
        for (int i = 0; i < 100; i++) model_mem[i] = 16'h0000;

        countBusy(20, cycles);
        checkOutput("restart_sweep_len", 32'(cycles), 32'd100);
        for (int i = 0; i < 100; i++) doOp(i, 16'h0, 1'b0, 1'b1, "post_wipe");

        // Overridden-parameter instance
        applyStimulus(1, 1'b0, 32'd15, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        checkOutput("p2.wr15.err", 32'(addr_error2), 32'd0);
        checkOutput("p2.wr15.busy", 32'(busy2), 32'd0);
        applyStimulus(1, 1'b0, 32'd15, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("p2.rd15.data", output_data2, 32'hDEADBEEF);
        checkOutput("p2.rd15.valid", 32'(read_valid2), 32'd1);
        applyStimulus(1, 1'b0, 32'd16, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("p2.rd16.err", 32'(addr_error2), 32'd1);
        checkOutput("p2.rd16.data", output_data2, 32'd0);
        checkOutput("p2.rd16.valid", 32'(read_valid2), 32'd1);
        applyStimulus(1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("p2.rst.busy", 32'(busy2), 32'd0);
        checkOutput("p2.rst.data", output_data2, 32'd0);
        checkOutput("p2.rst.valid", 32'(read_valid2), 32'd0);
        applyStimulus(1, 1'b0, 32'd15, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("p2.rd15_after_rst", output_data2, 32'hDEADBEEF);
        checkOutput("p2.rd15_after_rst.err", 32'(addr_error2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
